// File: rtl/stack_cpu_core.sv
// Multicycle stack CPU (fetch/decode/execute, operand stack in memory); STACK_CPU_BOUNDS_CHECK_EN enables stack faults.
// Latency: 2-5 cycles per instruction with mem_ready high, plus one cycle per stalled memory beat.
// Backpressure: any memory state holds its request stable until mem_ready; DECODE/HALT/ERROR issue no request.
module stack_cpu_core #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                OPC_W       = 6,
    parameter logic [ADDR_W-1:0] ENTRY_POINT = 'h0020,
    parameter logic [ADDR_W-1:0] STACK_START = 'hFFFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 'hFF00
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] pc_dbg
);
    localparam int IMM_W = DATA_W - OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_PUSHI = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_POP   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_JZ    = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_HALT  = '1;

`ifdef STACK_CPU_BOUNDS_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_POP1, S_POP2, S_MEMRD, S_PUSH, S_MEMWR, S_HALT, S_ERROR
    } state_t;

    state_t             state_q, state_nxt;
    logic               run_q;
    logic [ADDR_W-1:0]  pc_q, sp_q;
    logic [DATA_W-1:0]  a_q, b_q, ir_q;
    logic               halted_q;
    logic [1:0]         err_code_q;

    logic [OPC_W-1:0]   opc;
    logic [DATA_W-1:0]  imm_d;
    logic [ADDR_W-1:0]  imm_a, sp_inc, depth, sp_at_push;
    logic [1:0]         n_pops, dec_err;
    logic               needs_push, legal, underflow, overflow, xfer;
    logic [DATA_W-1:0]  alu_res, push_val;

    assign opc    = ir_q[DATA_W-1 -: OPC_W];
    assign imm_d  = {{OPC_W{1'b0}}, ir_q[IMM_W-1:0]};
    assign imm_a  = imm_d[ADDR_W-1:0];
    assign sp_inc = sp_q + ADDR_W'(1);
    assign xfer   = mem_req && mem_ready;

    always_comb begin
        n_pops     = 2'd0;
        needs_push = 1'b0;
        legal      = 1'b1;
        case (opc)
            OP_NOP, OP_JMP, OP_HALT: begin end
            OP_PUSHI:                needs_push = 1'b1;
            OP_POP, OP_JZ:           n_pops = 2'd1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                n_pops     = 2'd2;
                needs_push = 1'b1;
            end
            OP_LOAD: begin
                n_pops     = 2'd1;
                needs_push = 1'b1;
            end
            OP_STORE:                n_pops = 2'd2;
            default:                 legal = 1'b0;
        endcase
    end

    // Overflow is judged on SP as it will be when PUSH starts, i.e. after this instruction's pops.
    assign depth      = STACK_START - sp_q;
    assign sp_at_push = sp_q + ADDR_W'(n_pops);
    assign underflow  = CHECK_EN && (ADDR_W'(n_pops) > depth);
    assign overflow   = CHECK_EN && needs_push && (sp_at_push < STACK_LIMIT);
    assign dec_err    = !legal ? 2'd1 : underflow ? 2'd2 : overflow ? 2'd3 : 2'd0;

    always_comb begin
        alu_res = '0;
        case (opc)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
        push_val = (opc == OP_PUSHI) ? imm_d : (opc == OP_LOAD) ? b_q : alu_res;
    end

    always_comb begin
        state_nxt = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        case (state_q)
            S_FETCH: begin
                mem_req = run_q;
                if (run_q && mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (dec_err != 2'd0) state_nxt = S_ERROR;
                else begin
                    case (opc)
                        OP_NOP, OP_JMP: state_nxt = S_FETCH;
                        OP_PUSHI:       state_nxt = S_PUSH;
                        OP_HALT:        state_nxt = S_HALT;
                        default:        state_nxt = S_POP1;
                    endcase
                end
            end
            S_POP1: begin
                mem_req  = 1'b1;
                mem_addr = sp_inc;
                if (mem_ready) begin
                    case (opc)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STORE: state_nxt = S_POP2;
                        OP_LOAD: state_nxt = S_MEMRD;
                        default: state_nxt = S_FETCH;
                    endcase
                end
            end
            S_POP2: begin
                mem_req  = 1'b1;
                mem_addr = sp_inc;
                if (mem_ready) state_nxt = (opc == OP_STORE) ? S_MEMWR : S_PUSH;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = b_q[ADDR_W-1:0];
                if (mem_ready) state_nxt = S_PUSH;
            end
            S_PUSH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = push_val;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = b_q[ADDR_W-1:0];
                mem_wdata = a_q;
                if (mem_ready) state_nxt = S_FETCH;
            end
            default: state_nxt = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_nxt;
    end

    // run_q keeps the very first post-reset cycle free of memory traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            pc_q       <= ENTRY_POINT;
            sp_q       <= STACK_START;
            a_q        <= '0;
            b_q        <= '0;
            ir_q       <= '0;
            halted_q   <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_FETCH: if (xfer) begin
                    ir_q <= mem_rdata;
                    pc_q <= pc_q + ADDR_W'(1);
                end
                S_DECODE: begin
                    if (dec_err != 2'd0)    err_code_q <= dec_err;
                    else if (opc == OP_HALT) halted_q  <= 1'b1;
                    else if (opc == OP_JMP)  pc_q      <= imm_a;
                end
                S_POP1: if (xfer) begin
                    sp_q <= sp_inc;
                    b_q  <= mem_rdata;
                    if (opc == OP_JZ && mem_rdata == '0) pc_q <= imm_a;
                end
                S_POP2: if (xfer) begin
                    sp_q <= sp_inc;
                    a_q  <= mem_rdata;
                end
                S_MEMRD: if (xfer) b_q <= mem_rdata;
                S_PUSH:  if (xfer) sp_q <= sp_q - ADDR_W'(1);
                default: begin end
            endcase
        end
    end

    assign halted   = halted_q;
    assign error    = (err_code_q != 2'd0);
    assign err_code = err_code_q;
    assign pc_dbg   = pc_q;

endmodule
